seq_adder: RTL
==============

Name: seq_adder

Overview:
Parametrised sequential adder/subtractor; successor to the combinational half adder. Computes a WIDTH-bit add or subtract with carry-in, CHUNK bits per clock, over WIDTH/CHUNK cycles. Uses a valid/ready handshake on input and output so it can sit between pipeline stages of the arithmetic datapath. Reports carry-out and signed overflow.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 1.
CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH, WIDTH % CHUNK == 0 (elaboration-time assertion).

Ports:
clk_i  input  1  clock, rising edge.
rst_ni  input  1  synchronous, active-low reset.
valid_i  input  1  operands valid.
ready_o  output  1  block can accept operands.
a_i  input  WIDTH  operand A.
b_i  input  WIDTH  operand B.
cin_i  input  1  carry-in (add) or borrow-in (subtract).
sub_i  input  1  0 = add, 1 = subtract.
valid_o  output  1  result valid.
ready_i  input  1  downstream accepts result.
sum_o  output  WIDTH  result.
cout_o  output  1  carry-out; for subtract, 1 = no borrow.
ovf_o  output  1  two's-complement signed overflow.

Behaviour:
- One clock, clk_i. Reset is synchronous, active-low on rst_ni.
- NSLICES = WIDTH/CHUNK. States: IDLE, BUSY, DONE.
- Reset: state IDLE, slice index 0, valid_o 0, sum_o 0, cout_o 0, ovf_o 0. ready_o is 1 from the first cycle after reset is released.
- ready_o = (state == IDLE), decoded from state with no combinational path from valid_i. valid_o = (state == DONE).
- IDLE:
  - Input handshake is valid_i && ready_o.
  - Latch A, and B' = sub_i ? ~b_i : b_i.
  - Carry register = sub_i ? ~cin_i : cin_i. Subtract computes a - b - cin.
  - Clear slice index and go to BUSY.
- BUSY, each cycle:
  - Add slice [idx*CHUNK +: CHUNK] of A, B' and carry.
  - Write the slice into the sum register and update carry.
  - On the last slice, capture cout_o = final carry and ovf_o = carry into MSB ^ carry out of MSB.
  - Then go to DONE. Otherwise increment idx.
- DONE: sum_o, cout_o and ovf_o are stable. Hold until ready_i = 1, then go to IDLE.
- ready_i is ignored outside DONE.
- Latency: with the input handshake at edge T, valid_o rises at edge T+NSLICES. CHUNK == WIDTH gives 1 cycle. Throughput is one operation per NSLICES+2 cycles. There is no same-cycle re-accept on the DONE->IDLE transition.
- valid_i asserted while in BUSY or DONE is ignored. Operands are not queued.
- The sum register is updated only in BUSY. Between the output handshake and the next DONE, sum_o, cout_o and ovf_o keep the last result. Consumers must qualify them with valid_o.
- Arithmetic is modulo 2^WIDTH. There is no saturation.
- Reset asserted in any state, including mid-BUSY: the operation is aborted and the result discarded. Next cycle is IDLE with the reset values above.
- Slice index width is $clog2(NSLICES), minimum 1. The index never wraps past NSLICES-1.

Decomposition:
- Package seq_adder_pkg holds:
  - state enum typedef (IDLE, BUSY, DONE);
  - op enum (OP_ADD = 0, OP_SUB = 1).
- One sub-module, adder_slice: parametrised CHUNK-bit combinational ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and c_msb (carry into its top bit, used for ovf_o).
  - Instantiated once and muxed by slice index.

Test Plan:
1. WIDTH=32, CHUNK=8, add: a=0x0000_00FF, b=0x0000_0001, cin=0 -> sum_o=0x0000_0100, cout_o=0, ovf_o=0. valid_o rises exactly 4 edges after the accept edge; ready_o is low during that time.
2. Add: a=0xFFFF_FFFF, b=0x0000_0001, cin=0 -> sum_o=0, cout_o=1, ovf_o=0. a=0x7FFF_FFFF, b=1 -> sum_o=0x8000_0000, cout_o=0, ovf_o=1.
3. Subtract: a=7, b=5, cin=0 -> sum_o=2, cout_o=1. a=5, b=7, cin=0 -> sum_o=0xFFFF_FFFE, cout_o=0, ovf_o=0. a=5, b=2, cin=1 -> sum_o=2.
4. Backpressure: hold ready_i=0 for 5 cycles in DONE and pulse valid_i with new operands -> valid_o and outputs stay stable, new operands are ignored. Raise ready_i -> IDLE next cycle, ready_o=1.
5. Reset mid-operation: drop rst_ni for 1 cycle after 2 slices of a 32/8 add -> valid_o=0, sum_o=0, ready_o=1 after release. A following add 3+4 gives 7.
6. WIDTH=CHUNK=1, exhaustive a/b in {0,1} with cin=0 (legacy half-adder truth table) -> sum/cout = 0/0, 1/0, 1/0, 0/1, each with 1-cycle latency. Repeat with WIDTH=8, CHUNK=1 and 1000 random ops checked against a reference model.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types for the sequential adder/subtractor.
// Latency: n/a (types and elaboration helpers only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, operation encoding, index width helper.
package seq_adder_pkg;

  // Control FSM states: IDLE accepts operands, BUSY walks the slices,
  // DONE presents the result until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation select as carried on sub_i.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Width of an index/select able to address 'count' items, never below 1
  // so single-item cases still get a legal one-bit register.
  function automatic int sel_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// CHUNK-bit combinational adder: one slice of the sequential datapath.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle on whatever slice is selected.
//
// Ports:
//   a, b   : slice operands (b already inverted by the caller for subtract)
//   cin    : carry into bit 0 of the slice
//   sum    : slice result
//   cout   : carry out of the slice's top bit
//   c_msb  : carry into the slice's top bit (feeds signed-overflow detection)
module adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  // One extra bit of headroom captures the carry out of the slice.
  assign total = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(cin);
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

  // The top sum bit is a ^ b ^ carry-in at that position, so the carry into
  // the MSB can be recovered without building an explicit ripple chain.
  assign c_msb = sum[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/seq_adder.sv
// Sequential WIDTH-bit add/subtract with carry-in, CHUNK bits per clock.
// Latency: valid_o rises WIDTH/CHUNK edges after the input handshake edge.
// Backpressure: result held in DONE until ready_i; ready_o only in IDLE.
//
// Ports:
//   clk_i, rst_ni     : clock (rising edge), synchronous active-low reset
//   valid_i / ready_o : operand handshake (ready_o decoded from state only)
//   a_i, b_i          : operands
//   cin_i             : carry-in for add, borrow-in for subtract
//   sub_i             : 0 = a + b + cin, 1 = a - b - cin
//   valid_o / ready_i : result handshake
//   sum_o             : result modulo 2^WIDTH
//   cout_o            : carry-out; for subtract 1 means no borrow
//   ovf_o             : two's-complement signed overflow
module seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NSLICES = WIDTH / CHUNK;
  localparam int IDXW    = sel_width(NSLICES);
  localparam int BASEW   = sel_width(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

  // Reject parameter sets that would leave bits unprocessed.
  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_adder: WIDTH must be a positive multiple of CHUNK, 1 <= CHUNK <= WIDTH");
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;     // holds ~b for subtract
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d; // running carry between slices
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  // ------------------------------------------------------------------
  // Slice datapath: a single adder shared by all slices, selected by idx
  // ------------------------------------------------------------------
  op_e              op;
  logic             in_hs;
  logic [BASEW-1:0] base;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  assign op    = op_e'(sub_i);
  assign in_hs = valid_i && ready_o;

  // Bit offset of the current slice; always < WIDTH so the truncation is safe.
  assign base = BASEW'(32'(idx_q) * 32'(CHUNK));

  assign slice_a = a_q[base +: CHUNK];
  assign slice_b = b_q[base +: CHUNK];

  adder_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          // Subtract is a + ~b + ~borrow: a - b - cin in two's complement.
          a_d     = a_i;
          b_d     = (op == OP_SUB) ? ~b_i : b_i;
          carry_d = (op == OP_SUB) ? ~cin_i : cin_i;
          idx_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        sum_d[base +: CHUNK] = slice_sum;
        carry_d              = slice_cout;
        if (idx_q == LAST_IDX) begin
          // The last slice holds the word MSB, so its carries decide ovf.
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs: handshakes decoded from state only, results straight from flops
  // ------------------------------------------------------------------
  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign ovf_o   = ovf_q;

endmodule
